cache_req_arbiter: RTL
======================

Name: cache_req_arbiter

Overview:
Shares one bsg_cache request/response port among num_req_p requesters, such as tile endpoints or DMA. Arbitration is round-robin. The cache returns responses in order, so the block keeps an in-order ID FIFO and routes each response back to the requester that issued it. An ALOCK/AUNLOCK pair gives one requester exclusive access. The block sits between the requester crossbar and the cache input; the testbench cache_checker monitors the cache side unchanged.

Parameters:
num_req_p, 4, number of requesters (2..16)
data_width_p, 32, cache data width
addr_width_p, 32, cache packet address width
max_out_p, 4, maximum outstanding packets (ID FIFO depth, 2..16)
cache_pkt_width_lp, `bsg_cache_pkt_width(addr_width_p,data_width_p), derived
lg_req_lp, `BSG_SAFE_CLOG2(num_req_p), derived

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_pkt_i  in  num_req_p*cache_pkt_width_lp  per-requester cache packets
req_v_i  in  num_req_p  per-requester packet valid
req_ready_o  out  num_req_p  per-requester accept
req_data_o  out  data_width_p  response data (broadcast to all requesters)
req_v_o  out  num_req_p  one-hot response valid
req_yumi_i  in  num_req_p  per-requester response consume
cache_pkt_o  out  cache_pkt_width_lp  packet to cache
cache_v_o  out  1  packet valid to cache
cache_ready_i  in  1  cache ready
cache_data_i  in  data_width_p  cache response data
cache_v_i  in  1  cache response valid
cache_yumi_o  out  1  cache response consume

Behaviour:
- Reset (async assert, sync deassert internally): rr pointer=0, ID FIFO empty, outstanding count=0, lock state=UNLOCKED. cache_v_o, req_ready_o, req_v_o and cache_yumi_o are all 0 while reset_n_i is low.
- Eligible set:
  - UNLOCKED: all req_v_i.
  - LOCKED(k): req_v_i[k] only.
- Grant: combinational round-robin over the eligible set, starting at the rr pointer (highest priority).
- cache_v_o = (eligible set nonempty) & ~fifo_full. It never depends on cache_ready_i.
- cache_pkt_o = packet from the granted requester.
- req_ready_o[g] = cache_v_o & cache_ready_i for the granted g; 0 for all others.
- Accept occurs when cache_v_o & cache_ready_i. On accept:
  - push g into the ID FIFO;
  - rr pointer <= (g+1) mod num_req_p;
  - if opcode==ALOCK, state <= LOCKED(g);
  - if opcode==AUNLOCK while LOCKED(g), state <= UNLOCKED;
  - AUNLOCK while UNLOCKED is forwarded without a state change.
- In LOCKED(k) the rr pointer does not move.
- Response routing:
  - head = ID FIFO head.
  - req_v_o[head] = cache_v_i & ~fifo_empty; all other bits 0.
  - req_data_o = cache_data_i.
  - cache_yumi_o = req_yumi_i[head] & req_v_o[head]; this pops the FIFO.
  - Any yumi from a non-head requester is ignored.
- Latency: 0 cycles through the block on both paths; there are no pipeline registers.
- Full: when max_out_p packets are outstanding, cache_v_o=0, even if a pop occurs the same cycle (no bypass).
- Empty: cache_v_i while the FIFO is empty is a protocol error. Assert in simulation and never drive req_v_o.
- Simultaneous push and pop: allowed when not full; the count is unchanged.
- Reset mid-operation: all outstanding state is discarded. The cache must be reset in the same window.

Decomposition:
- Shared package cache_arb_pkg:
  - lock-state typedef (UNLOCKED, LOCKED);
  - ID width function;
  - opcodes come from bsg_cache_pkg.
- ID FIFO: one sub-module, bsg_fifo_1r1w_small (width lg_req_lp, els max_out_p).
- Round-robin grant: written inline.

Test Plan:
- Single requester: r0 issues SW 0x100=0xDEADBEEF then LW 0x100 -> both accepted back-to-back; req_v_o=4'b0001 twice; the second response returns 0xDEADBEEF.
- All 4 requesters hold req_v_i=1 with cache_ready_i=1 -> grants follow the order 0,1,2,3,0 on successive cycles; responses return one-hot to the same order.
- Full: max_out_p=4, cache_v_i held low, 5 requests pending -> exactly 4 accepted, cache_v_o=0 on cycle 5. One response pop -> the 5th is accepted on the following cycle, not the pop cycle.
- Lock: r2 sends ALOCK while r0, r1 and r3 are valid -> only r2 is granted until its AUNLOCK is accepted, then r3 is granted next.
- Backpressure: head response to r1 with req_yumi_i[1]=0 for 3 cycles, while r0 asserts yumi -> cache_yumi_o stays 0; data is held until r1 consumes.
- Reset: reset_n_i pulsed low with 3 packets outstanding -> all outputs are 0 immediately (async); after release the FIFO is empty and the rr pointer is 0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache request arbiter: lock state, the opcodes that
// affect arbitration, and helpers for ID and packet widths.
package cache_arb_pkg;

    localparam int opcode_width_lp = 6;

    // Subset of the bsg_cache opcode encodings; packets are {opcode, addr, data, mask}.
    typedef enum logic [opcode_width_lp-1:0] {
        LW      = 6'b000010,
        SW      = 6'b001010,
        ALOCK   = 6'b011011,
        AUNLOCK = 6'b011100
    } bsg_cache_opcode_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int pkt_width(input int addr_w, input int data_w);
        return opcode_width_lp + addr_w + data_w + data_w / 8;
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO holding the requester ID of each outstanding cache packet.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 2,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p <= 1) ? 1 : $clog2(els_p);
    localparam int cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [width_p-1:0]      storage [els_p];
    logic [ptr_width_lp-1:0] wr_ptr;
    logic [ptr_width_lp-1:0] rd_ptr;
    logic [cnt_width_lp-1:0] count;
    logic                    push;
    logic                    pop;

    assign ready_o = (count != full_cnt_lp);
    assign v_o     = (count != '0);
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;
    assign data_o  = storage[rd_ptr];

    // Pointers wrap explicitly so depths that are not powers of two work.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + ptr_width_lp'(1);
            if (pop)
                rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + ptr_width_lp'(1);
            count <= count + cnt_width_lp'(push) - cnt_width_lp'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            storage[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one bsg_cache port among several requesters, with
// in-order response routing and ALOCK/AUNLOCK exclusive access.
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int  num_req_p          = 4,
    parameter int  data_width_p       = 32,
    parameter int  addr_width_p       = 32,
    parameter int  max_out_p          = 4,
    localparam int cache_pkt_width_lp = pkt_width(addr_width_p, data_width_p),
    localparam int lg_req_lp          = id_width(num_req_p)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic [num_req_p*cache_pkt_width_lp-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]                    req_v_i,
    output logic [num_req_p-1:0]                    req_ready_o,
    output logic [data_width_p-1:0]                 req_data_o,
    output logic [num_req_p-1:0]                    req_v_o,
    input  logic [num_req_p-1:0]                    req_yumi_i,
    output logic [cache_pkt_width_lp-1:0]           cache_pkt_o,
    output logic                                    cache_v_o,
    input  logic                                    cache_ready_i,
    input  logic [data_width_p-1:0]                 cache_data_i,
    input  logic                                    cache_v_i,
    output logic                                    cache_yumi_o
);

    typedef logic [num_req_p-1:0] req_vec_t;

    logic [1:0]                 rst_sync;
    logic                       active;
    lock_state_e                lock_state;
    lock_state_e                lock_state_next;
    logic [lg_req_lp-1:0]       lock_id;
    logic [lg_req_lp-1:0]       lock_id_next;
    logic [lg_req_lp-1:0]       rr;
    logic [lg_req_lp-1:0]       rr_next;
    logic [lg_req_lp-1:0]       grant;
    logic [lg_req_lp-1:0]       head;
    req_vec_t                   eligible;
    req_vec_t                   upper;
    req_vec_t                   pick;
    logic                       fifo_ready;
    logic                       fifo_v;
    logic                       accept;
    logic                       resp_v;
    logic [opcode_width_lp-1:0] opcode;

    // Reset asserts immediately but releases on a clock edge; outputs are gated while it is held.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign active = rst_sync[1];

    // Requesters at or above the pointer win first; otherwise wrap to the lowest eligible.
    always_comb begin
        eligible = (lock_state == LOCKED) ? (req_v_i & (req_vec_t'(1) << lock_id)) : req_v_i;
        upper    = eligible & ~((req_vec_t'(1) << rr) - req_vec_t'(1));
        pick     = (upper != '0) ? upper : eligible;
        grant    = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (pick[i])
                grant = lg_req_lp'(i);
        end
    end

    assign cache_v_o   = active & (|eligible) & fifo_ready;
    assign cache_pkt_o = req_pkt_i[int'(grant) * cache_pkt_width_lp +: cache_pkt_width_lp];
    assign accept      = cache_v_o & cache_ready_i;
    assign req_ready_o = accept ? (req_vec_t'(1) << grant) : '0;
    assign opcode      = cache_pkt_o[cache_pkt_width_lp-1 -: opcode_width_lp];

    assign resp_v       = active & cache_v_i & fifo_v;
    assign req_v_o      = resp_v ? (req_vec_t'(1) << head) : '0;
    assign req_data_o   = cache_data_i;
    assign cache_yumi_o = resp_v & req_yumi_i[head];

    always_ff @(posedge clk_i or negedge active) begin
        if (!active) begin
            lock_state <= UNLOCKED;
            lock_id    <= '0;
            rr         <= '0;
        end else begin
            lock_state <= lock_state_next;
            lock_id    <= lock_id_next;
            rr         <= rr_next;
        end
    end

    // The pointer is frozen while locked so the requester after the owner goes next on unlock.
    always_comb begin
        lock_state_next = lock_state;
        lock_id_next    = lock_id;
        rr_next         = rr;
        if (accept) begin
            if (lock_state == UNLOCKED)
                rr_next = (grant == lg_req_lp'(num_req_p - 1)) ? '0 : grant + lg_req_lp'(1);
            if (opcode == ALOCK) begin
                lock_state_next = LOCKED;
                lock_id_next    = grant;
            end else if (opcode == AUNLOCK && lock_state == LOCKED && lock_id == grant) begin
                lock_state_next = UNLOCKED;
            end
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p(lg_req_lp),
        .els_p  (max_out_p)
    ) id_fifo (
        .clk_i    (clk_i),
        .reset_n_i(active),
        .v_i      (accept),
        .ready_o  (fifo_ready),
        .data_i   (grant),
        .v_o      (fifo_v),
        .data_o   (head),
        .yumi_i   (cache_yumi_o)
    );

    // A response with nothing outstanding means the cache and this block disagree.
    resp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!active)
        !(cache_v_i && !fifo_v));

endmodule
